// File: rtl/prbs26_checker.sv
// Self-synchronising checker for the 26-bit PRBS (b[t] = b[t-18]^b[t-19]^b[t-25]^b[t-26]).
// Locks after LOCK_CNT consecutive good predictions, then counts errors and detects loss of lock.
module prbs26_checker #(
   parameter int unsigned LOCK_CNT    = 64,
   parameter int unsigned WIN_LEN     = 1024,
   parameter int unsigned LOSS_THRESH = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam int unsigned HIST_LEN = 26;
   localparam int unsigned FILL_W   = 5;
   localparam int unsigned MATCH_W  = $clog2(LOCK_CNT + 1);
   localparam int unsigned WIN_W    = $clog2(WIN_LEN);
   localparam int unsigned ERR_W    = $clog2(LOSS_THRESH + 1);

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t             state, state_d;
   logic [26:1]        hist, hist_d;
   logic [FILL_W-1:0]  fill, fill_d;
   logic [MATCH_W-1:0] match, match_d;
   logic [WIN_W-1:0]   win_cnt, win_cnt_d;
   logic [ERR_W-1:0]   win_err, win_err_d;
   logic               locked_d, err_pulse_d;
   logic [CNT_W-1:0]   err_cnt_d, bit_cnt_d;
   logic               pred, err, loss;

   assign pred = hist[18] ^ hist[19] ^ hist[25] ^ hist[26];
   assign err  = in_bit ^ pred;
   assign loss = err && (win_err == ERR_W'(LOSS_THRESH - 1));

   // State register; every output is a flop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= SEARCH;
         hist      <= '0;
         fill      <= '0;
         match     <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_cnt   <= '0;
         bit_cnt   <= '0;
      end else begin
         state     <= state_d;
         hist      <= hist_d;
         fill      <= fill_d;
         match     <= match_d;
         win_cnt   <= win_cnt_d;
         win_err   <= win_err_d;
         locked    <= locked_d;
         err_pulse <= err_pulse_d;
         err_cnt   <= err_cnt_d;
         bit_cnt   <= bit_cnt_d;
      end
   end

   // Next-state and output logic; idle cycles hold everything except err_pulse
   always_comb begin
      state_d     = state;
      hist_d      = hist;
      fill_d      = fill;
      match_d     = match;
      win_cnt_d   = win_cnt;
      win_err_d   = win_err;
      err_pulse_d = 1'b0;
      err_cnt_d   = err_cnt;
      bit_cnt_d   = bit_cnt;

      if (in_valid) begin
         case (state)
            SEARCH: begin
               hist_d = {hist[25:1], in_bit};
               if (fill != FILL_W'(HIST_LEN)) begin
                  fill_d = fill + FILL_W'(1);
               end else if (err) begin
                  match_d = '0;
               end else if (match == MATCH_W'(LOCK_CNT - 1)) begin
                  state_d   = LOCKED;
                  match_d   = '0;
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  match_d = match + MATCH_W'(1);
               end
            end
            LOCKED: begin
               // Reference runs free on its own prediction so one bad bit counts once
               hist_d      = {hist[25:1], pred};
               err_pulse_d = err;
               if (bit_cnt != '1) bit_cnt_d = bit_cnt + CNT_W'(1);
               if (err && (err_cnt != '1)) err_cnt_d = err_cnt + CNT_W'(1);
               if (loss) begin
                  state_d   = SEARCH;
                  fill_d    = '0;
                  match_d   = '0;
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  win_cnt_d = win_cnt + WIN_W'(1);
                  if (err) win_err_d = win_err + ERR_W'(1);
               end
            end
            default: state_d = SEARCH;
         endcase
      end

      if (clr_cnt) begin
         err_cnt_d = '0;
         bit_cnt_d = '0;
      end

      locked_d = (state_d == LOCKED);
   end

endmodule

// File: tb/tb_prbs26_checker.sv
// Directed bench for prbs26_checker: lock timing, single errors, window loss, gaps, clear, saturation.
module tb_prbs26_checker;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_bit, clr_cnt;
   logic        locked, err_pulse, locked4, err_pulse4;
   logic [31:0] err_cnt, bit_cnt;
   logic [3:0]  err_cnt4, bit_cnt4;

   logic [26:1] gen;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   prbs26_checker dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
      .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
   );

   prbs26_checker #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
      .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4), .bit_cnt(bit_cnt4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: valid bits come from the reference sequence, optionally inverted
   task automatic step(input logic v, input logic flip, input logic clr);
      logic b;
      if (v) begin
         b      = gen[18] ^ gen[19] ^ gen[25] ^ gen[26];
         gen    = {gen[25:1], b};
         in_bit = b ^ flip;
      end else begin
         in_bit = 1'($urandom);
      end
      in_valid = v;
      clr_cnt  = clr;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clr_cnt  = 1'b0;
   endtask

   task automatic good(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
   endtask

   // Feed good bits (with optional idle gaps) and report the valid-sample count at lock
   task automatic acquire(input string tag, input bit gaps);
      int nvalid = 0;
      int got    = 0;
      for (int cyc = 0; cyc < 2000 && got == 0; cyc++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            step(1'b0, 1'b0, 1'b0);
            check("idle_no_lock", 32'(locked), 32'd0);
         end else begin
            step(1'b1, 1'b0, 1'b0);
            nvalid++;
            if (locked) got = nvalid;
         end
      end
      check(tag, 32'(got), 32'd90);
   endtask

   initial begin
      logic [31:0] saved;
      rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
      gen = 26'h0000001;
      repeat (3) step(1'b0, 1'b0, 1'b0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_pulse", 32'(err_pulse), 32'd0);
      check("rst_err_cnt", err_cnt, 32'd0);
      check("rst_bit_cnt", bit_cnt, 32'd0);
      rst_n = 1'b1;

      // Initial acquisition
      acquire("lock_latency", 1'b0);
      check("lock_err_cnt", err_cnt, 32'd0);
      check("lock_bit_cnt", bit_cnt, 32'd0);
      good(10);
      check("bit_cnt_10", bit_cnt, 32'd10);

      // Single flip: one pulse, one count, no multiplication
      step(1'b1, 1'b1, 1'b0);
      check("flip_pulse", 32'(err_pulse), 32'd1);
      check("flip_err_cnt", err_cnt, 32'd1);
      check("flip_locked", 32'(locked), 32'd1);
      step(1'b1, 1'b0, 1'b0);
      check("flip_pulse_off", 32'(err_pulse), 32'd0);
      good(50);
      check("flip_no_mult", err_cnt, 32'd1);
      check("flip_still_locked", 32'(locked), 32'd1);
      good(962);

      // Clear on an idle cycle at the window boundary; lock unaffected
      step(1'b0, 1'b0, 1'b1);
      check("clr_err_cnt", err_cnt, 32'd0);
      check("clr_bit_cnt", bit_cnt, 32'd0);
      check("clr_locked", 32'(locked), 32'd1);

      // 15 errors in each of two windows: no loss
      for (int i = 0; i < 15; i++) begin step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); end
      good(994);
      for (int i = 0; i < 15; i++) begin step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); end
      check("two_win_locked", 32'(locked), 32'd1);
      check("two_win_err_cnt", err_cnt, 32'd30);
      check("two_win_bit_cnt", bit_cnt, 32'd1054);
      good(994);

      // 16 errors in one window: loss on the 16th
      for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0);
      check("pre_loss_locked", 32'(locked), 32'd1);
      step(1'b1, 1'b1, 1'b0);
      check("loss_locked", 32'(locked), 32'd0);
      check("loss_pulse", 32'(err_pulse), 32'd1);
      check("loss_err_cnt", err_cnt, 32'd46);
      check("loss_bit_cnt", bit_cnt, 32'd2064);
      acquire("relock_latency", 1'b0);
      check("relock_bit_cnt", bit_cnt, 32'd2064);

      // Narrow counters saturate
      check("sat_err_cnt4", 32'(err_cnt4), 32'd15);
      check("sat_bit_cnt4", 32'(bit_cnt4), 32'd15);
      step(1'b1, 1'b1, 1'b0);
      check("sat_hold_err_cnt4", 32'(err_cnt4), 32'd15);

      // Reset while locked, with an error on the same cycle
      rst_n = 1'b0;
      step(1'b1, 1'b1, 1'b0);
      rst_n = 1'b1;
      check("mid_rst_locked", 32'(locked), 32'd0);
      check("mid_rst_pulse", 32'(err_pulse), 32'd0);
      check("mid_rst_err_cnt", err_cnt, 32'd0);
      check("mid_rst_bit_cnt", bit_cnt, 32'd0);
      check("mid_rst_locked4", 32'(locked4), 32'd0);
      check("mid_rst_err_cnt4", 32'(err_cnt4), 32'd0);

      // Acquisition with idle gaps counts valid samples only
      gen = 26'h0000001;
      acquire("gap_lock_latency", 1'b1);
      good(3);
      saved = bit_cnt;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("idle_hold_bit_cnt", bit_cnt, saved);
      check("idle_hold_locked", 32'(locked), 32'd1);

      // Clear wins over an error increment on the same cycle
      step(1'b1, 1'b1, 1'b1);
      check("clr_vs_err_cnt", err_cnt, 32'd0);
      check("clr_vs_err_pulse", 32'(err_pulse), 32'd1);
      check("clr_vs_bit_cnt", bit_cnt, 32'd0);
      step(1'b1, 1'b0, 1'b0);
      check("post_clr_err_cnt", err_cnt, 32'd0);
      check("post_clr_bit_cnt", bit_cnt, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
